// File: rtl/unidade_hazard.sv
// Pipeline hazard controller: load-use stalls, branch flushes, multi-cycle EX waits and memory freezes.
// Optional build macro HAZARD_STATS_EN adds the cnt_stall / cnt_flush event counters.
module unidade_hazard #(
   parameter int MC_LAT      = 4,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rs1_ID,
   input  logic [4:0] rs2_ID,
   input  logic [4:0] rd_EX,
   input  logic       MemRead_EX,
   input  logic       branch_taken_EX,
   input  logic       mc_start_EX,
   input  logic       mem_req_MEM,
   input  logic       mem_ready_MEM,
   output logic       stall_PC,
   output logic       stall_IFID,
   output logic       stall_IDEX,
   output logic       stall_EXMEM,
   output logic       flush_IFID,
   output logic       flush_IDEX,
   output logic       bolha_EXMEM,
   output logic       mc_busy,
   output logic       mem_erro,
   output logic [1:0] estado
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] cnt_stall,
   output logic [31:0] cnt_flush
`endif
);

   typedef enum logic [1:0] {
      NORMAL  = 2'b00,
      MC_WAIT = 2'b01,
      ERRO    = 2'b10
   } estado_t;

   localparam logic [3:0] MC_LOAD    = 4'(MC_LAT - 2);
   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

   estado_t    estado_q, estado_d;
   logic [3:0] mc_cnt_q, mc_cnt_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       freeze, load_use;
   logic       s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, bolha, busy, erro;

   assign freeze   = mem_req_MEM & ~mem_ready_MEM;
   assign load_use = MemRead_EX & (rd_EX != 5'd0) & ((rd_EX == rs1_ID) | (rd_EX == rs2_ID));

   // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
   always_comb begin
      estado_d   = estado_q;
      mc_cnt_d   = mc_cnt_q;
      wait_cnt_d = 8'd0;
      s_pc       = 1'b0;
      s_ifid     = 1'b0;
      s_idex     = 1'b0;
      s_exmem    = 1'b0;
      f_ifid     = 1'b0;
      f_idex     = 1'b0;
      bolha      = 1'b0;
      erro       = 1'b0;
      busy       = (estado_q == MC_WAIT);

      if (freeze)
         wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;

      if (estado_q == ERRO) begin
         {s_pc, s_ifid, s_idex, s_exmem} = 4'b1111;
         erro = 1'b1;
      end else if (freeze) begin
         // Whole pipe holds; the multi-cycle countdown pauses with it.
         {s_pc, s_ifid, s_idex, s_exmem} = 4'b1111;
         if (wait_cnt_q == WAIT_LIMIT)
            estado_d = ERRO;
      end else if (estado_q == MC_WAIT) begin
         if (mc_cnt_q != 4'd0) begin
            {s_pc, s_ifid, s_idex} = 3'b111;
            bolha    = 1'b1;
            mc_cnt_d = mc_cnt_q - 4'd1;
         end else begin
            estado_d = NORMAL;
         end
      end else if (mc_start_EX) begin
         {s_pc, s_ifid, s_idex} = 3'b111;
         bolha    = 1'b1;
         mc_cnt_d = MC_LOAD;
         estado_d = MC_WAIT;
      end else if (branch_taken_EX) begin
         f_ifid = 1'b1;
         f_idex = 1'b1;
      end else if (load_use) begin
         s_pc   = 1'b1;
         s_ifid = 1'b1;
         f_idex = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q   <= NORMAL;
         mc_cnt_q   <= 4'd0;
         wait_cnt_q <= 8'd0;
      end else begin
         estado_q   <= estado_d;
         mc_cnt_q   <= mc_cnt_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Reset overrides everything combinationally, even before the first edge.
   assign stall_PC    = ~rst & s_pc;
   assign stall_IFID  = ~rst & s_ifid;
   assign stall_IDEX  = ~rst & s_idex;
   assign stall_EXMEM = ~rst & s_exmem;
   assign flush_IFID  = ~rst & f_ifid;
   assign flush_IDEX  = ~rst & f_idex;
   assign bolha_EXMEM = ~rst & bolha;
   assign mc_busy     = ~rst & busy;
   assign mem_erro    = ~rst & erro;
   assign estado      = rst ? 2'b00 : estado_q;

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_stall <= 32'd0;
         cnt_flush <= 32'd0;
      end else begin
         if (stall_PC)
            cnt_stall <= cnt_stall + 32'd1;
         if (flush_IDEX | bolha_EXMEM)
            cnt_flush <= cnt_flush + 32'd1;
      end
   end
`endif

endmodule
